// File: rtl/async_multi_rx.sv
// Multi-byte 8N1 UART receiver: assembles up to eight bytes into one 64-bit word.
// Short messages are delivered after an idle gap with RxD_timeout set.
module async_multi_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int GAP_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    input  logic [3:0]  RxD_bytes,
    output logic [63:0] RxD_data,
    output logic [3:0]  RxD_len,
    output logic        RxD_valid,
    output logic        RxD_timeout,
    output logic        frame_err,
    output logic        busy
);

    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int GAP_CLKS = GAP_BITS * CPB;
    localparam int CW       = $clog2(GAP_CLKS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(GAP_CLKS - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        ERR
    } state_t;

    state_t         state_q, state_d;
    logic           s1_q, s2_q;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     sr_q, sr_d;
    logic [63:0]    asm_q, asm_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     lim_q, lim_d;
    logic [63:0]    data_q, data_d;
    logic [3:0]     len_q, len_d;
    logic           valid_q, valid_d;
    logic           tmo_q, tmo_d;
    logic           ferr_q, ferr_d;
    logic           rxs;

    assign rxs = s2_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        data_d    = data_q;
        len_d     = len_q;
        valid_d   = 1'b0;
        tmo_d     = tmo_q;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    asm_d     = '0;
                    cnt_d     = '0;
                    lim_d     = (RxD_bytes == 4'd0 || RxD_bytes > 4'd8)
                              ? 4'd8 : RxD_bytes;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rxs ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    sr_d      = {rxs, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        asm_d   = '0;
                        cnt_d   = '0;
                        state_d = ERR;
                    end else begin
                        asm_d[{cnt_q[2:0], 3'b000} +: 8] = sr_q;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == lim_q) begin
                            data_d  = asm_d;
                            len_d   = cnt_q + 4'd1;
                            valid_d = 1'b1;
                            tmo_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE;
                end
            end
            GAP: begin
                if (!rxs) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (clk_cnt_q == GAP_M1) begin
                    data_d  = asm_q;
                    len_d   = cnt_q;
                    valid_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE;
                end
            end
            ERR: begin
                // Line must stay idle for a whole bit before a new start is trusted.
                if (!rxs) begin
                    clk_cnt_d = '0;
                end else if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            asm_q     <= '0;
            cnt_q     <= '0;
            lim_q     <= '0;
            data_q    <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= RxD;
            s2_q      <= s1_q;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            data_q    <= data_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            ferr_q    <= ferr_d;
        end
    end

    assign RxD_data    = data_q;
    assign RxD_len     = len_q;
    assign RxD_valid   = valid_q;
    assign RxD_timeout = tmo_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_async_multi_rx.sv
// Directed bench for async_multi_rx at 10 clocks per bit.
// Bytes are driven onto RxD bit by bit; delivered words are captured by a monitor.
module tb_async_multi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RxD = 1'b1;
    logic [3:0]  RxD_bytes = 4'd8;
    logic [63:0] RxD_data;
    logic [3:0]  RxD_len;
    logic        RxD_valid;
    logic        RxD_timeout;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    int fcnt  = 0;
    int v0, f0;

    always #5 clk = ~clk;

    async_multi_rx #(
        .CLK_FREQ(100_000_000),
        .BAUD    (10_000_000),
        .GAP_BITS(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .RxD_bytes  (RxD_bytes),
        .RxD_data   (RxD_data),
        .RxD_len    (RxD_len),
        .RxD_valid  (RxD_valid),
        .RxD_timeout(RxD_timeout),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (RxD_valid) vcnt++;
        if (frame_err) fcnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic v);
        RxD = v;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bits(1'b0);
        for (int i = 0; i < 8; i++) send_bits(b[i]);
        send_bits(stop);
        RxD = 1'b1;
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] m1 [8];
        m1 = '{8'h55, 8'h00, 8'hFF, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hAA};

        repeat (3) @(negedge clk);
        check("rst_data", RxD_data, 64'h0);
        check("rst_valid", {63'h0, RxD_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        rst = 1'b1;
        idle(5);

        // 8-byte message
        v0 = vcnt;
        RxD_bytes = 4'd8;
        send_byte(m1[0], 1'b1);
        check("t1_busy", {63'h0, busy}, 64'h1);
        for (int i = 1; i < 8; i++) send_byte(m1[i], 1'b1);
        idle(10);
        check("t1_vcnt", 64'(vcnt - v0), 64'd1);
        check("t1_data", RxD_data, 64'hAAFF0055AAFF0055);
        check("t1_len", {60'h0, RxD_len}, 64'd8);
        check("t1_tmo", {63'h0, RxD_timeout}, 64'h0);
        check("t1_busy0", {63'h0, busy}, 64'h0);

        // 3-byte message
        v0 = vcnt;
        RxD_bytes = 4'd3;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(10);
        check("t2_vcnt", 64'(vcnt - v0), 64'd1);
        check("t2_data", RxD_data, 64'h0000_0000_0033_2211);
        check("t2_len", {60'h0, RxD_len}, 64'd3);

        // start-bit glitch
        v0 = vcnt;
        f0 = fcnt;
        RxD = 1'b0;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_busy1", {63'h0, busy}, 64'h1);
        idle(10);
        check("t3_busy0", {63'h0, busy}, 64'h0);
        check("t3_vcnt", 64'(vcnt - v0), 64'd0);
        check("t3_fcnt", 64'(fcnt - f0), 64'd0);

        // framing error then clean message
        v0 = vcnt;
        f0 = fcnt;
        RxD_bytes = 4'd4;
        send_byte(8'hA0, 1'b1);
        send_byte(8'hC3, 1'b0);
        idle(30);
        check("t4_fcnt", 64'(fcnt - f0), 64'd1);
        check("t4_vcnt0", 64'(vcnt - v0), 64'd0);
        check("t4_busy", {63'h0, busy}, 64'h0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        idle(10);
        check("t4_vcnt1", 64'(vcnt - v0), 64'd1);
        check("t4_data", RxD_data, 64'h04030201);
        check("t4_len", {60'h0, RxD_len}, 64'd4);

        // gap timeout with short message
        v0 = vcnt;
        RxD_bytes = 4'd4;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        idle(150);
        check("t5_early", 64'(vcnt - v0), 64'd0);
        idle(100);
        check("t5_vcnt", 64'(vcnt - v0), 64'd1);
        check("t5_tmo", {63'h0, RxD_timeout}, 64'h1);
        check("t5_len", {60'h0, RxD_len}, 64'd2);
        check("t5_data", RxD_data, 64'hB2A1);

        // single-byte message, no timeout
        v0 = vcnt;
        RxD_bytes = 4'd1;
        send_byte(8'h7E, 1'b1);
        idle(10);
        check("t7_vcnt", 64'(vcnt - v0), 64'd1);
        check("t7_data", RxD_data, 64'h7E);
        check("t7_tmo", {63'h0, RxD_timeout}, 64'h0);

        // reset mid-message
        RxD_bytes = 4'd8;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_bits(1'b0);
        send_bits(1'b1);
        send_bits(1'b0);
        rst = 1'b0;
        #1;
        check("t6_data", RxD_data, 64'h0);
        check("t6_len", {60'h0, RxD_len}, 64'h0);
        check("t6_busy", {63'h0, busy}, 64'h0);
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        v0 = vcnt;
        idle(20);
        check("t6_noout", 64'(vcnt - v0), 64'd0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        idle(10);
        check("t6_vcnt", 64'(vcnt - v0), 64'd1);
        check("t6_word", RxD_data, 64'h0807060504030201);

        // RxD_bytes=0 means eight bytes
        v0 = vcnt;
        RxD_bytes = 4'd0;
        for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b1);
        idle(10);
        check("t8_vcnt", 64'(vcnt - v0), 64'd1);
        check("t8_data", RxD_data, 64'hF7F6F5F4F3F2F1F0);
        check("t8_tmo", {63'h0, RxD_timeout}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
